periph_bank: RTL and testbench

- Parametrised successor to the fixed memory-mapped LED/timer peripherals: N PWM channels of configurable resolution, programmable PWM period and prescaler, millis/micros timers, and a millis compare-match interrupt.
- Decodes the data-memory port (address, funct3, wren) in parallel with data memory.
- Returns load data one cycle after the access, sign- or zero-extended per funct3.
- The top level muxes its read data in using `hit`.

---
 rtl/periph_pkg.sv | 72 +++++++
 rtl/periph_bank_if.sv | 12 +
 rtl/pwm_channel.sv | 30 +++
 rtl/periph_bank.sv | 145 ++++++++++++++
 tb/tb_periph_bank.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/periph_pkg.sv
// Shared constants and bus-lane helpers for the memory-mapped peripheral bank.
// load_extend is written to be reusable by the data-memory read path.
package periph_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PERIOD   = 8'h04;
  localparam logic [7:0] OFF_PRESCALE = 8'h08;
  localparam logic [7:0] OFF_MILLIS   = 8'h0C;
  localparam logic [7:0] OFF_MICROS   = 8'h10;
  localparam logic [7:0] OFF_CMP      = 8'h14;
  localparam logic [7:0] OFF_STATUS   = 8'h18;
  localparam logic [7:0] OFF_DUTY     = 8'h20;

  localparam int CTRL_PWM_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STATUS_IRQ  = 0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] mask;
  } wr_lane_t;

  // Replicate store data onto every lane; the mask picks the lanes that land.
  function automatic wr_lane_t store_lanes(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    wr_lane_t s;
    case (f3)
      F3_SB: begin
        s.data = {4{d[7:0]}};
        s.mask = 32'h0000_00FF << {a, 3'b000};
      end
      F3_SH: begin
        s.data = {2{d[15:0]}};
        s.mask = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      end
      default: begin
        s.data = d;
        s.mask = 32'hFFFF_FFFF;
      end
    endcase
    return s;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input wr_lane_t s);
    return (old & ~s.mask) | (s.data & s.mask);
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LBU:  return {24'h0, b};
      F3_LHU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/periph_bank_if.sv
// Data-memory side port of the peripheral bank, decoded in parallel with RAM.
interface periph_bank_if;
  logic [2:0]  funct3;
  logic        wren;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hit;

  modport slave  (input funct3, wren, address, data_in, output data_out, hit);
  modport master (output funct3, wren, address, data_in, input data_out, hit);
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active duty pair and the registered output compare.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [PWM_BITS-1:0] wdata,
  input  logic                load,
  input  logic                pwm_en,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  logic [PWM_BITS-1:0] duty_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty     <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (we)   duty     <= wdata;
      if (load) duty_act <= duty;
      pwm <= pwm_en && (pwm_cnt < duty_act);
    end
  end

endmodule

// File: rtl/periph_bank.sv
// Memory-mapped peripheral bank: N PWM channels with shared period/prescaler,
// free-running millis/micros timers and a millis compare-match interrupt.
module periph_bank
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFFFF00,
  parameter int          N_CHANNELS = 4,
  parameter int          PWM_BITS   = 8,
  parameter int          CLK_FREQ   = 12000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  periph_bank_if.slave          bus,
  output logic [N_CHANNELS-1:0] pwm_out,
  output logic                  irq
);

  localparam int US_DIV = CLK_FREQ / 1000000;
  localparam int MS_DIV = CLK_FREQ / 1000;

  logic [5:0]  woff;
  logic        wr;
  wr_lane_t    lanes;

  logic [1:0]          ctrl;
  logic [PWM_BITS-1:0] period;
  logic [15:0]         prescale;
  logic [31:0]         cmp, millis, micros, us_div, ms_div;
  logic                irq_pending;
  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_CHANNELS-1:0][PWM_BITS-1:0] duty;

  logic [31:0] rd, rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic        us_tick, ms_tick, tick, wrap, cmp_set, sts_clr;

  assign woff    = bus.address[7:2];
  assign bus.hit = (bus.address[31:8] == BASE_ADDR[31:8]);
  assign wr      = bus.wren && bus.hit;
  assign lanes   = store_lanes(bus.funct3, bus.address[1:0], bus.data_in);

  assign us_tick = (us_div == 32'(US_DIV - 1));
  assign ms_tick = (ms_div == 32'(MS_DIV - 1));
  assign tick    = ctrl[CTRL_PWM_EN] && (pre_cnt >= prescale);
  assign wrap    = tick && (pwm_cnt >= period);
  // Only a MILLIS increment can raise the flag, so a CMP write never does.
  assign cmp_set = ms_tick && ((millis + 32'd1) == cmp);
  assign sts_clr = wr && (woff == OFF_STATUS[7:2]) && lanes.mask[STATUS_IRQ]
                   && lanes.data[STATUS_IRQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      period   <= '1;
      prescale <= '0;
      cmp      <= '0;
    end else if (wr) begin
      case (woff)
        OFF_CTRL[7:2]:     ctrl     <= 2'(merge({30'h0, ctrl}, lanes));
        OFF_PERIOD[7:2]:   period   <= PWM_BITS'(merge(32'(period), lanes));
        OFF_PRESCALE[7:2]: prescale <= 16'(merge({16'h0, prescale}, lanes));
        OFF_CMP[7:2]:      cmp      <= merge(cmp, lanes);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      us_div      <= '0;
      ms_div      <= '0;
      micros      <= '0;
      millis      <= '0;
      irq_pending <= 1'b0;
      irq         <= 1'b0;
    end else begin
      us_div      <= us_tick ? 32'd0 : us_div + 32'd1;
      ms_div      <= ms_tick ? 32'd0 : ms_div + 32'd1;
      micros      <= micros + 32'(us_tick);
      millis      <= millis + 32'(ms_tick);
      irq_pending <= cmp_set || (irq_pending && !sts_clr);
      irq         <= irq_pending && ctrl[CTRL_IRQ_EN];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!ctrl[CTRL_PWM_EN]) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr && (woff == OFF_DUTY[7:2] + 6'(i))),
      .wdata   (PWM_BITS'(merge(32'(duty[i]), lanes))),
      .load    (wrap || !ctrl[CTRL_PWM_EN]),
      .pwm_en  (ctrl[CTRL_PWM_EN]),
      .pwm_cnt (pwm_cnt),
      .duty    (duty[i]),
      .pwm     (pwm_out[i])
    );
  end

  always_comb begin
    rd = '0;
    case (woff)
      OFF_CTRL[7:2]:     rd = {30'h0, ctrl};
      OFF_PERIOD[7:2]:   rd = 32'(period);
      OFF_PRESCALE[7:2]: rd = {16'h0, prescale};
      OFF_MILLIS[7:2]:   rd = millis;
      OFF_MICROS[7:2]:   rd = micros;
      OFF_CMP[7:2]:      rd = cmp;
      OFF_STATUS[7:2]:   rd = {31'h0, irq_pending};
      default:
        for (int i = 0; i < N_CHANNELS; i++)
          if (woff == OFF_DUTY[7:2] + 6'(i)) rd = 32'(duty[i]);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
      f3_q <= '0;
      a_q  <= '0;
    end else begin
      rd_q <= bus.hit ? rd : 32'h0;
      f3_q <= bus.funct3;
      a_q  <= bus.address[1:0];
    end
  end

  assign bus.data_out = load_extend(rd_q, f3_q, a_q);

endmodule

// File: tb/tb_periph_bank.sv
// Directed + randomized bench for periph_bank (4 channels, 8-bit PWM, 2 MHz clock).
module tb_periph_bank;
  import periph_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] pwm_out;
  logic irq;
  int vectors = 0, miscompares = 0;
  int cyc = 0;

  periph_bank_if bus();

  periph_bank #(.BASE_ADDR(32'hFFFFFF00), .N_CHANNELS(4), .PWM_BITS(8), .CLK_FREQ(2000000))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus), .pwm_out(pwm_out), .irq(irq));

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  // pwm_out[1] monitor: lengths of high runs, rise-to-rise gaps, high sample count
  int hi_runs[$], gaps[$];
  int run = 0, last_rise = -1, nsamp = 0, hi_total = 0;
  logic prev = 1'b0;
  always @(negedge clk) begin
    if (pwm_out[1]) begin
      run++; hi_total++;
      if (!prev) begin
        if (last_rise >= 0) gaps.push_back(nsamp - last_rise);
        last_rise = nsamp;
      end
    end else if (run > 0) begin
      hi_runs.push_back(run); run = 0;
    end
    prev = pwm_out[1];
    nsamp++;
  end

  task automatic clear_mon();
    hi_runs.delete(); gaps.delete();
    run = 0; last_rise = -1; nsamp = 0; hi_total = 0; prev = pwm_out[1];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    bus.funct3 = f; bus.address = a; bus.data_in = d; bus.wren = 1'b1;
    @(posedge clk); #1;
    bus.wren = 1'b0; bus.address = 32'h0;
  endtask

  task automatic load(input logic [2:0] f, input logic [31:0] a, output logic [31:0] q);
    bus.funct3 = f; bus.address = a; bus.wren = 1'b0;
    @(posedge clk); #1;
    q = bus.data_out; bus.address = 32'h0;
  endtask

  task automatic wait_runs(input string tag, input int n, input int budget);
    int t = 0;
    while (hi_runs.size() < n && t < budget) begin @(posedge clk); #1; t++; end
    check(tag, 32'(hi_runs.size() >= n), 32'd1);
  endtask

  task automatic wait_pwm1(input string tag, input logic lvl, input int budget);
    int t = 0;
    while (pwm_out[1] !== lvl && t < budget) begin @(posedge clk); #1; t++; end
    check(tag, 32'(pwm_out[1]), 32'(lvl));
  endtask

  // Register model: word-indexed contents, implemented-bit masks, byte-lane access
  logic [31:0] m [0:63];
  function automatic logic [31:0] mmask(input int w);
    case (w)
      0: return 32'h3;
      1: return 32'hFF;
      2: return 32'hFFFF;
      5: return 32'hFFFF_FFFF;
      8, 9, 10, 11: return 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic mstore(input int w, input int f3, input int lo, input logic [31:0] d);
    int sz, st;
    logic [31:0] t;
    sz = 1 << f3; st = lo & ~(sz - 1); t = m[w];
    for (int k = 0; k < sz; k++) t[8*(st+k) +: 8] = d[8*k +: 8];
    m[w] = t & mmask(w);
  endtask

  function automatic logic [31:0] mload(input int w, input int f3, input int lo);
    int sz, st;
    longint v, lim;
    sz = 1 << (f3 & 3); st = lo & ~(sz - 1);
    v = longint'(m[w]) >> (8*st);
    lim = 64'd1 << (8*sz);
    if (sz < 4) begin
      v = v % lim;
      if (f3 < 4 && v >= lim / 2) v = v - lim;
    end
    return v[31:0];
  endfunction

  initial begin
    logic [31:0] q, d;
    int w, f, lo, k;
    int wlist[8]  = '{0, 1, 2, 5, 8, 9, 10, 11};
    int alist[12] = '{0, 1, 2, 5, 8, 9, 10, 11, 7, 12, 17, 63};
    int lf[5]     = '{0, 1, 2, 4, 5};

    bus.funct3 = 3'h0; bus.wren = 1'b0; bus.address = 32'h0; bus.data_in = 32'h0;
    #12;
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk); reset_n = 1'b1;

    load(F3_LW, 32'hFFFFFF04, q); check("rst_period", q, 32'h0000_00FF);
    load(F3_LW, 32'hFFFFFF20, q); check("rst_duty0", q, 32'h0);
    bus.address = 32'hFFFFFF10; #1; check("hit_in", 32'(bus.hit), 32'd1);
    bus.address = 32'hFFFFFE10; #1; check("hit_out", 32'(bus.hit), 32'd0);
    bus.address = 32'h0;

    // PWM: 64/256 duty on channel 1
    store(F3_SW, 32'hFFFFFF00, 32'h1);
    store(F3_SB, 32'hFFFFFF24, 32'h40);
    store(F3_SW, 32'hFFFFFF08, 32'h0);
    store(F3_SW, 32'hFFFFFF04, 32'hFF);
    clear_mon();
    wait_runs("pwm_runs_timeout", 3, 1200);
    check("pwm_hi64_a", hi_runs[1], 32'd64);
    check("pwm_hi64_b", hi_runs[2], 32'd64);
    check("pwm_period", gaps[1], 32'd256);

    // mid-period duty change takes effect on the following period
    wait_pwm1("pwm_low_wait", 1'b0, 600);
    clear_mon();
    wait_pwm1("pwm_high_wait", 1'b1, 600);
    step(5);
    store(F3_SB, 32'hFFFFFF24, 32'h80);
    wait_runs("pwm_mid_timeout", 2, 1200);
    check("pwm_mid_keep64", hi_runs[0], 32'd64);
    check("pwm_next128", hi_runs[1], 32'd128);

    store(F3_SB, 32'hFFFFFF24, 32'h00);
    step(300); clear_mon(); step(512);
    check("pwm_duty0_low", hi_total, 32'd0);

    store(F3_SW, 32'hFFFFFF04, 32'd9);
    store(F3_SB, 32'hFFFFFF24, 32'd10);
    step(40); clear_mon(); step(100);
    check("pwm_duty_gt_period", hi_total, 32'd100);

    // load extension
    store(F3_SW, 32'hFFFFFF20, 32'hFFFFFF80);
    load(F3_LB,  32'hFFFFFF20, q); check("lb_duty0", q, 32'hFFFFFF80);
    load(F3_LBU, 32'hFFFFFF20, q); check("lbu_duty0", q, 32'h0000_0080);
    load(F3_LH,  32'hFFFFFF22, q); check("lh_hi", q, 32'h0);
    load(F3_LHU, 32'hFFFFFF22, q); check("lhu_hi", q, 32'h0);
    store(F3_SH, 32'hFFFFFF20, 32'h0000ABCD);
    load(F3_LW,  32'hFFFFFF20, q); check("sh_duty0", q, 32'h0000_00CD);

    // randomized register traffic against the lane model
    for (int i = 0; i < 8; i++) begin
      d = $urandom; store(F3_SW, {24'hFFFFFF, 6'(wlist[i]), 2'b00}, d); mstore(wlist[i], 2, 0, d);
    end
    for (int i = 0; i < 60; i++) begin
      w = alist[$urandom_range(0, 11)];
      if ($urandom_range(0, 1) == 1) begin
        f = $urandom_range(0, 2); lo = $urandom_range(0, 3) & ~((1 << f) - 1); d = $urandom;
        store(3'(f), {24'hFFFFFF, 6'(w), 2'(lo)}, d); mstore(w, f, lo, d);
      end
      f = lf[$urandom_range(0, 4)]; lo = $urandom_range(0, 3) & ~((1 << (f & 3)) - 1);
      load(3'(f), {24'hFFFFFF, 6'(w), 2'(lo)}, q);
      check("rand_load", q, mload(w, f, lo));
    end
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 5);
      load(F3_LW, {24'(k), 6'd1, 2'b00}, q); check("miss_load", q, 32'h0);
    end

    // compare-match interrupt, timed from a fresh reset
    @(negedge clk); reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    store(F3_SW, 32'hFFFFFF14, 32'd3);
    store(F3_SW, 32'hFFFFFF00, 32'h3);
    while (cyc < 6000) begin @(posedge clk); #1; end
    check("irq_pre_6000", 32'(irq), 32'd0);
    step(1);
    check("irq_6001", 32'(irq), 32'd1);
    load(F3_LW, 32'hFFFFFF0C, q); check("millis_3", q, 32'((cyc - 1) / 2000));
    store(F3_SW, 32'hFFFFFF18, 32'h1);
    step(1);
    check("irq_w1c", 32'(irq), 32'd0);
    store(F3_SW, 32'hFFFFFF14, 32'd3);
    step(5);
    check("irq_cmp_eq_write", 32'(irq), 32'd0);
    load(F3_LW, 32'hFFFFFF18, q); check("status_clear", q, 32'h0);
    store(F3_SW, 32'hFFFFFF14, 32'd4);
    while (cyc < 7999) begin @(posedge clk); #1; end
    store(F3_SW, 32'hFFFFFF18, 32'h1);
    step(1);
    check("irq_set_wins", 32'(irq), 32'd1);
    load(F3_LW, 32'hFFFFFF18, q); check("status_set_wins", q, 32'h1);

    // async reset mid-period while irq is high
    store(F3_SB, 32'hFFFFFF24, 32'hC0);
    wait_pwm1("pwm_before_rst", 1'b1, 700);
    check("irq_before_rst", 32'(irq), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_pwm", 32'(pwm_out), 32'h0);
    check("rst_async_irq", 32'(irq), 32'h0);
    step(3);
    check("rst_hold_pwm", 32'(pwm_out), 32'h0);
    @(negedge clk); reset_n = 1'b1;
    load(F3_LW, 32'hFFFFFF0C, q); check("millis_after_rst", q, 32'h0);
    load(F3_LW, 32'hFFFFFF00, q); check("ctrl_after_rst", q, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
